// File: rtl/sb_dma_master_pkg.sv
// Shared bus constants and DMA state encodings for the sb m1 DMA master.
package sb_dma_master_pkg;

   // Byte-select field of the system bus
   localparam int          BYTE_SEL_W   = 4;
   localparam logic [3:0]  SL_WORD      = 4'b1111;
   localparam logic [3:0]  SL_NONE      = 4'b0000;
   localparam logic        UNSIGNED     = 1'b1;
   localparam logic [31:0] ZERO32       = 32'h0000_0000;
   localparam logic        READ_ENABLE  = 1'b1;
   localparam logic        WRITE_ENABLE = 1'b1;

   // DMA engine states (2-bit)
   typedef enum logic [1:0] {
      DMA_IDLE = 2'd0,
      DMA_RD   = 2'd1,
      DMA_WR   = 2'd2,
      DMA_DONE = 2'd3
   } dma_state_e;

endpackage

// File: rtl/sb_dma_master.sv
// Word-copy DMA engine on the sb m1 master port. Reads one word from src,
// writes it to dst, repeats len times. m0 (core) has bus priority, so every
// beat waits for m1_grant.
// Optional: define SB_DMA_FILL_EN to add a fill mode that writes a constant
// word to every dst location without reading.
module sb_dma_master
   import sb_dma_master_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int ADDR_STEP = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [31:0]           src_addr,
   input  logic [31:0]           dst_addr,
   input  logic [LEN_W-1:0]      len,
`ifdef SB_DMA_FILL_EN
   input  logic                  fill_mode,
   input  logic [31:0]           fill_data,
`endif
   input  logic                  m1_grant,
   input  logic [31:0]           m1_rdata,
   output logic                  m1_un_sign_o,
   output logic [BYTE_SEL_W-1:0] m1_byte_mask_o,
   output logic                  m1_re_o,
   output logic                  m1_we_o,
   output logic [31:0]           m1_addr_o,
   output logic [31:0]           m1_wdata_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  aborted_o,
   output logic [LEN_W-1:0]      words_done_o
);

   localparam logic [31:0]      STEP = 32'(ADDR_STEP);
   localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

   dma_state_e       state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [31:0]      buf_q, buf_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             aborted_q, aborted_d;
   logic [LEN_W-1:0] cnt_inc;
   logic             last_word;

   // fill_start: fill requested at start; fill_act: current transfer is a fill
   logic             fill_start;
   logic             fill_act;
   logic [31:0]      fill_word;

`ifdef SB_DMA_FILL_EN
   logic             fill_q, fill_d;
   assign fill_start = fill_mode;
   assign fill_act   = fill_q;
   assign fill_word  = fill_data;
`else
   assign fill_start = 1'b0;
   assign fill_act   = 1'b0;
   assign fill_word  = ZERO32;
`endif

   assign cnt_inc   = cnt_q + ONE;
   assign last_word = (cnt_inc == len_q);

   // State and datapath registers; reset clears everything so a reset mid-beat
   // drops the bus request on the very next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DMA_IDLE;
         src_q     <= ZERO32;
         dst_q     <= ZERO32;
         buf_q     <= ZERO32;
         len_q     <= '0;
         cnt_q     <= '0;
         aborted_q <= 1'b0;
`ifdef SB_DMA_FILL_EN
         fill_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         buf_q     <= buf_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         aborted_q <= aborted_d;
`ifdef SB_DMA_FILL_EN
         fill_q    <= fill_d;
`endif
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      buf_d     = buf_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      aborted_d = aborted_q;
`ifdef SB_DMA_FILL_EN
      fill_d    = fill_q;
`endif
      case (state_q)
         DMA_IDLE: begin
            if (start) begin
               // Any accepted start begins a fresh transfer record
               cnt_d     = '0;
               aborted_d = 1'b0;
               if (len == '0) begin
                  state_d = DMA_DONE;
               end else begin
                  src_d = src_addr;
                  dst_d = dst_addr;
                  len_d = len;
`ifdef SB_DMA_FILL_EN
                  fill_d = fill_mode;
`endif
                  if (fill_start) begin
                     buf_d   = fill_word;
                     state_d = DMA_WR;
                  end else begin
                     state_d = DMA_RD;
                  end
               end
            end
         end
         DMA_RD: begin
            // Abort wins over a grant: the pending word is never written
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DMA_DONE;
            end else if (m1_grant) begin
               buf_d   = m1_rdata;
               state_d = DMA_WR;
            end
         end
         DMA_WR: begin
            if (m1_grant) begin
               dst_d = dst_q + STEP;
               if (!fill_act) src_d = src_q + STEP;
               cnt_d = cnt_inc;
               if (abort) aborted_d = 1'b1;
               if (last_word || abort) state_d = DMA_DONE;
               else if (fill_act)      state_d = DMA_WR;
               else                    state_d = DMA_RD;
            end else if (abort) begin
               aborted_d = 1'b1;
               state_d   = DMA_DONE;
            end
         end
         DMA_DONE: begin
            state_d = DMA_IDLE;
         end
         default: state_d = DMA_IDLE;
      endcase
   end

   // Bus and status outputs are a pure function of state, so a stalled beat
   // holds every output stable until granted.
   always_comb begin
      m1_un_sign_o   = UNSIGNED;
      m1_byte_mask_o = SL_NONE;
      m1_re_o        = 1'b0;
      m1_we_o        = 1'b0;
      m1_addr_o      = ZERO32;
      m1_wdata_o     = ZERO32;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      case (state_q)
         DMA_RD: begin
            m1_re_o        = READ_ENABLE;
            m1_byte_mask_o = SL_WORD;
            m1_addr_o      = src_q;
            busy_o         = 1'b1;
         end
         DMA_WR: begin
            m1_we_o        = WRITE_ENABLE;
            m1_byte_mask_o = SL_WORD;
            m1_addr_o      = dst_q;
            m1_wdata_o     = buf_q;
            busy_o         = 1'b1;
         end
         DMA_DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign aborted_o    = aborted_q;
   assign words_done_o = cnt_q;

endmodule

// File: doc/sb_dma_master.md
Name: sb_dma_master

Overview:
- Memory-to-memory word-copy engine that drives the system bus m1 master port. The core's load/store path owns m0.
- Lets software or a loader move blocks in dmem without core load/store traffic.
- Sits beside the core in the SoC top. Its m1_* outputs connect to the sb m1 inputs, and sb's m1_rdata_o and m1 grant come back in.
- Control comes from a small register front end: start, src, dst, len.

Parameters:
- LEN_W, 16, width of word-count field; max transfer 2^LEN_W-1 words
- ADDR_STEP, 4, byte increment per word for src and dst

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  stop after current bus beat; go to DONE
- src_addr  in  32  byte address of first source word
- dst_addr  in  32  byte address of first destination word
- len  in  LEN_W  number of 32-bit words to copy
- m1_grant  in  1  sb grants m1 this cycle; m0 has priority
- m1_rdata  in  32  read data from sb, valid in granted read cycle
- m1_un_sign_o  out  1  always `UNSIGNED
- m1_byte_mask_o  out  `BYTE_SEL  `SL_WORD when re/we active, else `SL_NONE
- m1_re_o  out  1  read request
- m1_we_o  out  1  write request
- m1_addr_o  out  32  bus address
- m1_wdata_o  out  32  write data
- busy_o  out  1  high in RD, WR, DONE
- done_o  out  1  one-cycle pulse in DONE
- aborted_o  out  1  sticky; set when abort ended a transfer, cleared on next accepted start
- words_done_o  out  LEN_W  count of words written in current/last transfer

Behaviour:
- Reset, synchronous, active-high: state IDLE. All outputs 0, except m1_byte_mask_o=`SL_NONE and m1_un_sign_o=`UNSIGNED. Internal src/dst/cnt/buffer are 0.
- Reset mid-transfer: bus requests drop on the next edge, no partial write occurs, and words_done_o clears.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 and len!=0: latch src, dst, len; clear words_done_o and aborted_o; go to RD.
  - start=1 and len==0: go to DONE. No bus activity.
  - start while not IDLE: ignored.
- RD:
  - Drive m1_re_o=1, m1_addr_o=src.
  - On an edge with m1_grant=1: capture m1_rdata into buf, go to WR.
  - m1_grant=0: hold all outputs stable.
- WR:
  - Drive m1_we_o=1, m1_addr_o=dst, m1_wdata_o=buf.
  - On an edge with m1_grant=1: src+=ADDR_STEP, dst+=ADDR_STEP, words_done_o+=1.
  - Then go to DONE if words_done_o+1==len or abort=1; else go to RD.
- Abort:
  - Sampled in RD: go to DONE immediately. No write for the pending word.
  - Sampled in WR: the write completes only if granted that edge; otherwise go straight to DONE with no write.
  - aborted_o is set in both cases.
- DONE: done_o=1 and busy_o=1 for exactly one cycle; then IDLE.
- re and we are never both high. Address outputs are 0 when idle.
- Addresses are 32-bit modulo and wrap past 0xFFFFFFFC without error. Low two address bits pass through unchanged; alignment is the caller's responsibility.
- Timing, uncontended: 2 cycles per word. A transfer of N words holds busy for 2N+1 cycles, beginning the cycle after the start edge.

Optional Feature:
- Macro: SB_DMA_FILL_EN.
- Defined:
  - Extra inputs fill_mode (1) and fill_data (32), both latched at start.
  - fill_mode=1 skips RD entirely (IDLE->WR, WR->WR) and writes fill_data to every dst word, at 1 cycle per word uncontended.
  - src is ignored and does not increment.
- Not defined: ports absent, copy-only behaviour.

Decomposition:
- Shared constants in defines.v: `BYTE_SEL, `SL_WORD, `SL_NONE, `UNSIGNED, `ZERO32, `READ_ENABLE/`WRITE_ENABLE.
- New in defines.v: DMA state encodings DMA_IDLE/DMA_RD/DMA_WR/DMA_DONE (2-bit).
- No sub-module. Single FSM plus datapath registers.

Test Plan:
- src=0x100, dst=0x200, len=3, grant tied 1: reads 0x100/0x104/0x108, writes 0x200/0x204/0x208 with matching data. busy 7 cycles, done on 7th, words_done=3.
- Same transfer with grant low for 2 cycles in the second RD: outputs stay stable (re=1, addr=0x104) while stalled. Transfer completes 2 cycles later with data intact.
- len=0 start: no re/we ever asserted. done pulses the cycle after start. words_done=0.
- abort asserted in WR of word 2 of len=5, grant=1 that edge: 2 words written, aborted_o=1, done pulse. A following start clears aborted_o.
- src=0xFFFFFFFC, len=2: second read at 0x00000000 (wrap). A start pulsed mid-transfer is ignored.
- rst pulsed during WR: next cycle IDLE with all outputs at reset values. With SB_DMA_FILL_EN, fill_mode=1, fill_data=0xA5A5A5A5, len=4: four consecutive writes, no reads, busy 5 cycles.
